alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  Reservation station feeding the integer ALU: buffers dispatched ALU ops and snoops both CDBs
//  for missing operands. Issues one ready op per cycle on the ALU's valid/opr1/opr2/dependency/op
//  interface. Sits between dispatch and the ALU; the ALU result returns on the ALU CDB.
// PARAMETERS
//  RS_SIZE          8   entries; power of two, >=2
//  ROB_SIZE_WIDTH   4   ROB index width; tags are ROB_SIZE_WIDTH+1 bits, all-ones = no tag
//  CALC_OP_L1_WIDTH 4   ALU level-1 opcode width (`CALC_OP_L1_NUM_WIDTH)
// PORTS
//  clk_in          in   1    clock
//  rst_in          in   1    async reset, active-low
//  rdy_in          in   1    global enable; low = hold all state
//  need_flush_in   in   1    mispredict flush, synchronous
//  disp_valid_in   in   1    dispatch request
//  disp_op_L1_in   in   L1W  opcode level 1
//  disp_op_L2_in   in   1    opcode level 2 (ADD/SUB, SRL/SRA)
//  disp_vj_in      in   32   operand 1 value (valid when disp_qj_in all-ones)
//  disp_qj_in      in   T    operand 1 producer tag, T=ROB_SIZE_WIDTH+1
//  disp_vk_in      in   32   operand 2 value
//  disp_qk_in      in   T    operand 2 producer tag
//  disp_rob_in     in   T    destination ROB tag
//  full_out        out  1    all entries busy
//  alu_cdb_rdy_in  in   1    ALU CDB valid
//  alu_cdb_val_in  in   32   ALU CDB value
//  alu_cdb_dep_in  in   T    ALU CDB tag
//  lsb_cdb_rdy_in  in   1    LSB CDB valid
//  lsb_cdb_val_in  in   32   LSB CDB value
//  lsb_cdb_dep_in  in   T    LSB CDB tag
//  alu_valid_out   out  1    issue to ALU
//  alu_opr1_out    out  32   operand 1
//  alu_opr2_out    out  32   operand 2
//  alu_dep_out     out  T    destination tag
//  alu_op_L1_out   out  L1W  opcode level 1
//  alu_op_L2_out   out  1    opcode level 2
// BEHAVIOUR
//  Reset (rst_in=0, async): all busy=0, alu_valid_out=0, opr1/opr2=0, alu_dep_out=all-ones,
//   op outs=0; full_out=0. Age state cleared.
//  rdy_in=0: no state or output changes (alu_valid_out holds).
//  Entry: busy, op_L1, op_L2, vj, qj, vk, qk, rob. Operand ready iff its q is all-ones.
//  full_out = combinational AND of registered busy bits.
//  Dispatch: disp_valid_in && !full_out writes lowest-index free entry at the edge. While full,
//   dispatch is ignored (dispatcher must gate on full_out). A slot freed by an issue in the same
//   cycle is not visible to dispatch until the next cycle.
//  Dispatch bypass: if disp_qj_in (or qk) equals a CDB tag valid in the same cycle, capture that
//   value and store q=all-ones. If both CDBs match, the ALU CDB wins.
//  Wakeup: every cycle, each busy entry with q==CDB tag (CDB valid) latches the value and sets
//   q=all-ones. Two CDBs are handled in parallel; the ALU CDB wins on a tag collision.
//  Select: pick among busy entries whose registered qj and qk are both all-ones (a same-cycle
//   wakeup is not eligible). Default policy: lowest index. If one is found, drive alu_* registered
//   at the edge with alu_valid_out=1 and clear that entry's busy. Otherwise alu_valid_out=0;
//   data outputs hold.
//  Latency: dispatch with ready operands at edge N -> alu_valid_out=1 after edge N+1.
//   Wakeup at edge N -> earliest issue after edge N+1.
//  Dispatch, wakeup and issue in one cycle are legal and touch distinct entries.
//  need_flush_in=1 (rdy_in=1): clear all busy bits and alu_valid_out=0. Dispatch in that
//   cycle is dropped. Flush takes priority over all other updates.
//  No arithmetic here. Tags are compared at full width T; all-ones never matches a CDB tag.
// CONFIGURATION
//  ALU_RS_AGE_SELECT_EN defined: maintain an RS_SIZE x RS_SIZE age matrix.
//   - On dispatch to i: older[j][i]=1 for every busy j, and older[i][*]=0.
//   - Select issues the ready entry with no older ready entry (oldest-first).
//   - Flush and reset clear the matrix.
//  Undefined: lowest-index-ready select, no age state. Port list identical in both builds.
// TESTING
//  1 Reset low mid-run -> outputs show reset values immediately; no issue after release until a dispatch.
//  2 Dispatch ADD vj=5 vk=7 both tags all-ones, rob=3 at edge 0 -> edge 1: alu_valid_out=1,
//    opr1=5, opr2=7, dep=3, op_L1=0, op_L2=0. Next cycle alu_valid_out=0.
//  3 Dispatch SUB qj=2 vk=1 rob=4; two cycles later LSB CDB tag=2 val=0x10 -> issue the following
//    cycle with opr1=0x10, opr2=1, dep=4. Same test with the CDB in the dispatch cycle -> issue next cycle.
//  4 Fill 8 entries, all waiting on tag 9 -> full_out=1; 9th dispatch ignored; ALU CDB tag 9
//    -> 8 consecutive issues in index order; full_out drops after the first.
//  5 Three entries pending; need_flush_in=1 together with a dispatch -> all busy cleared,
//    alu_valid_out=0, full_out=0; no later issue of any of them.
//  6 AGE_SELECT_EN: dispatch A(qj=5) to entry 0, then B (ready) to entry 1, free entry 0 path
//    not taken; wake A -> B issues before A. Then free 0, dispatch C ready into entry 0 while B is
//    ready -> the oldest entry issues first. Without the macro, entry 0 wins.

Source files
------------

// File: rtl/alu_rs_if.sv
// Bus bundle between the ALU reservation station and its neighbours: dispatch, both CDBs
// and the ALU issue port. The slave modport is the RS view; master is the driver side.
interface alu_rs_if #(
  parameter int unsigned ROB_SIZE_WIDTH   = 4,
  parameter int unsigned CALC_OP_L1_WIDTH = 4
);
  localparam int unsigned TagW = ROB_SIZE_WIDTH + 1;

  logic                        rdy_in;
  logic                        need_flush_in;
  logic                        disp_valid_in;
  logic [CALC_OP_L1_WIDTH-1:0] disp_op_L1_in;
  logic                        disp_op_L2_in;
  logic [31:0]                 disp_vj_in;
  logic [TagW-1:0]             disp_qj_in;
  logic [31:0]                 disp_vk_in;
  logic [TagW-1:0]             disp_qk_in;
  logic [TagW-1:0]             disp_rob_in;
  logic                        full_out;
  logic                        alu_cdb_rdy_in;
  logic [31:0]                 alu_cdb_val_in;
  logic [TagW-1:0]             alu_cdb_dep_in;
  logic                        lsb_cdb_rdy_in;
  logic [31:0]                 lsb_cdb_val_in;
  logic [TagW-1:0]             lsb_cdb_dep_in;
  logic                        alu_valid_out;
  logic [31:0]                 alu_opr1_out;
  logic [31:0]                 alu_opr2_out;
  logic [TagW-1:0]             alu_dep_out;
  logic [CALC_OP_L1_WIDTH-1:0] alu_op_L1_out;
  logic                        alu_op_L2_out;

  modport master (
    output rdy_in, need_flush_in, disp_valid_in, disp_op_L1_in, disp_op_L2_in,
    output disp_vj_in, disp_qj_in, disp_vk_in, disp_qk_in, disp_rob_in,
    output alu_cdb_rdy_in, alu_cdb_val_in, alu_cdb_dep_in,
    output lsb_cdb_rdy_in, lsb_cdb_val_in, lsb_cdb_dep_in,
    input  full_out, alu_valid_out, alu_opr1_out, alu_opr2_out, alu_dep_out,
    input  alu_op_L1_out, alu_op_L2_out
  );

  modport slave (
    input  rdy_in, need_flush_in, disp_valid_in, disp_op_L1_in, disp_op_L2_in,
    input  disp_vj_in, disp_qj_in, disp_vk_in, disp_qk_in, disp_rob_in,
    input  alu_cdb_rdy_in, alu_cdb_val_in, alu_cdb_dep_in,
    input  lsb_cdb_rdy_in, lsb_cdb_val_in, lsb_cdb_dep_in,
    output full_out, alu_valid_out, alu_opr1_out, alu_opr2_out, alu_dep_out,
    output alu_op_L1_out, alu_op_L2_out
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ALU ops, snoops the ALU and LSB CDBs for
// missing operands and issues one ready op per cycle.
// Optional macro ALU_RS_AGE_SELECT_EN: oldest-ready select via an age matrix; otherwise
// the lowest-index ready entry issues.
module alu_rs #(
  parameter int unsigned RS_SIZE          = 8,
  parameter int unsigned ROB_SIZE_WIDTH   = 4,
  parameter int unsigned CALC_OP_L1_WIDTH = 4
) (
  input logic     clk_in,
  input logic     rst_in,
  alu_rs_if.slave bus
);
  localparam int unsigned TagW = ROB_SIZE_WIDTH + 1;
  localparam int unsigned IdxW = $clog2(RS_SIZE);
  localparam logic [TagW-1:0] NoTag = '1;

  logic [RS_SIZE-1:0]          busy_q;
  logic [CALC_OP_L1_WIDTH-1:0] op_l1_q [RS_SIZE];
  logic [RS_SIZE-1:0]          op_l2_q;
  logic [31:0]                 vj_q    [RS_SIZE];
  logic [31:0]                 vk_q    [RS_SIZE];
  logic [TagW-1:0]             qj_q    [RS_SIZE];
  logic [TagW-1:0]             qk_q    [RS_SIZE];
  logic [TagW-1:0]             rob_q   [RS_SIZE];

  logic                        alu_valid_q;
  logic [31:0]                 opr1_q, opr2_q;
  logic [TagW-1:0]             dep_q;
  logic [CALC_OP_L1_WIDTH-1:0] out_l1_q;
  logic                        out_l2_q;

  logic                full;
  logic [RS_SIZE-1:0]  ready;
  logic [RS_SIZE-1:0]  cand;
  logic [IdxW-1:0]     free_idx;
  logic [IdxW-1:0]     sel_idx;
  logic                sel_found;

  logic            a_rdy, l_rdy;
  logic [TagW-1:0] a_dep, l_dep;
  logic [31:0]     a_val, l_val;

  assign a_rdy = bus.alu_cdb_rdy_in;
  assign a_dep = bus.alu_cdb_dep_in;
  assign a_val = bus.alu_cdb_val_in;
  assign l_rdy = bus.lsb_cdb_rdy_in;
  assign l_dep = bus.lsb_cdb_dep_in;
  assign l_val = bus.lsb_cdb_val_in;

  // All-ones means "no producer" and must never match a broadcast tag.
  function automatic logic cdb_hit(input logic [TagW-1:0] q);
    return (q != NoTag) && ((a_rdy && q == a_dep) || (l_rdy && q == l_dep));
  endfunction

  // ALU CDB has priority when both buses carry the same tag.
  function automatic logic [31:0] cdb_val(input logic [TagW-1:0] q, input logic [31:0] v);
    if (q != NoTag && a_rdy && q == a_dep) return a_val;
    if (q != NoTag && l_rdy && q == l_dep) return l_val;
    return v;
  endfunction

  assign full             = &busy_q;
  assign bus.full_out     = full;
  assign bus.alu_valid_out = alu_valid_q;
  assign bus.alu_opr1_out = opr1_q;
  assign bus.alu_opr2_out = opr2_q;
  assign bus.alu_dep_out  = dep_q;
  assign bus.alu_op_L1_out = out_l1_q;
  assign bus.alu_op_L2_out = out_l2_q;

`ifdef ALU_RS_AGE_SELECT_EN
  // older_q[j][i] set means entry j was dispatched before entry i.
  logic [RS_SIZE-1:0] older_q [RS_SIZE];

  // Age matrix: new entry is younger than every busy entry; cleared by flush and reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
    end else if (bus.rdy_in) begin
      if (bus.need_flush_in) begin
        for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
      end else if (bus.disp_valid_in && !full) begin
        for (int j = 0; j < RS_SIZE; j++) begin
          older_q[j][free_idx] <= busy_q[j];
        end
        older_q[free_idx] <= '0;
      end
    end
  end
`endif

  // Readiness uses registered tags only, so a same-cycle wakeup is not eligible.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == NoTag) && (qk_q[i] == NoTag);
    end
`ifdef ALU_RS_AGE_SELECT_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      cand[i] = ready[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        if (ready[j] && older_q[j][i]) cand[i] = 1'b0;
      end
    end
`else
    cand = ready;
`endif
  end

  // Lowest-index free slot for dispatch and lowest-index candidate for issue.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
      if (cand[i]) begin
        sel_idx   = IdxW'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Entry state and issue registers; flush overrides wakeup, dispatch and issue.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q  <= '0;
      op_l2_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_l1_q[i] <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= NoTag;
        qk_q[i]    <= NoTag;
        rob_q[i]   <= NoTag;
      end
      alu_valid_q <= 1'b0;
      opr1_q      <= '0;
      opr2_q      <= '0;
      dep_q       <= NoTag;
      out_l1_q    <= '0;
      out_l2_q    <= 1'b0;
    end else if (bus.rdy_in) begin
      if (bus.need_flush_in) begin
        busy_q      <= '0;
        alu_valid_q <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && cdb_hit(qj_q[i])) begin
            vj_q[i] <= cdb_val(qj_q[i], vj_q[i]);
            qj_q[i] <= NoTag;
          end
          if (busy_q[i] && cdb_hit(qk_q[i])) begin
            vk_q[i] <= cdb_val(qk_q[i], vk_q[i]);
            qk_q[i] <= NoTag;
          end
        end
        if (bus.disp_valid_in && !full) begin
          busy_q[free_idx]  <= 1'b1;
          op_l1_q[free_idx] <= bus.disp_op_L1_in;
          op_l2_q[free_idx] <= bus.disp_op_L2_in;
          vj_q[free_idx]    <= cdb_val(bus.disp_qj_in, bus.disp_vj_in);
          qj_q[free_idx]    <= cdb_hit(bus.disp_qj_in) ? NoTag : bus.disp_qj_in;
          vk_q[free_idx]    <= cdb_val(bus.disp_qk_in, bus.disp_vk_in);
          qk_q[free_idx]    <= cdb_hit(bus.disp_qk_in) ? NoTag : bus.disp_qk_in;
          rob_q[free_idx]   <= bus.disp_rob_in;
        end
        if (sel_found) begin
          busy_q[sel_idx] <= 1'b0;
          alu_valid_q     <= 1'b1;
          opr1_q          <= vj_q[sel_idx];
          opr2_q          <= vk_q[sel_idx];
          dep_q           <= rob_q[sel_idx];
          out_l1_q        <= op_l1_q[sel_idx];
          out_l2_q        <= op_l2_q[sel_idx];
        end else begin
          alu_valid_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: vector table plus directed multi-cycle sequences,
// with issued ops checked against an in-order expected-result queue.
module tb_alu_rs;
  localparam logic [4:0] NT = 5'h1f;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_rs_if #(.ROB_SIZE_WIDTH(4), .CALC_OP_L1_WIDTH(4)) bus ();

  alu_rs #(.RS_SIZE(8), .ROB_SIZE_WIDTH(4), .CALC_OP_L1_WIDTH(4)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op1;
    logic        op2;
    logic [31:0] vj;
    logic [4:0]  qj;
    logic [31:0] vk;
    logic [4:0]  qk;
    logic [4:0]  rob;
    logic        a_rdy;
    logic [4:0]  a_tag;
    logic [31:0] a_val;
    logic        l_rdy;
    logic [4:0]  l_tag;
    logic [31:0] l_val;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [4:0]  dep;
    logic [3:0]  l1;
    logic        l2;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid_in  = 1'b0;
    bus.need_flush_in  = 1'b0;
    bus.alu_cdb_rdy_in = 1'b0;
    bus.lsb_cdb_rdy_in = 1'b0;
  endtask

  task automatic disp_set(input logic [3:0] op1, input logic op2, input logic [31:0] vj,
                          input logic [4:0] qj, input logic [31:0] vk, input logic [4:0] qk,
                          input logic [4:0] rob);
    bus.disp_valid_in = 1'b1;
    bus.disp_op_L1_in = op1;
    bus.disp_op_L2_in = op2;
    bus.disp_vj_in    = vj;
    bus.disp_qj_in    = qj;
    bus.disp_vk_in    = vk;
    bus.disp_qk_in    = qk;
    bus.disp_rob_in   = rob;
  endtask

  task automatic dispatch(input logic [3:0] op1, input logic op2, input logic [31:0] vj,
                          input logic [4:0] qj, input logic [31:0] vk, input logic [4:0] qk,
                          input logic [4:0] rob);
    disp_set(op1, op2, vj, qj, vk, qk, rob);
    step();
    bus.disp_valid_in = 1'b0;
  endtask

  task automatic cdb(input bit alu, input logic [4:0] tag, input logic [31:0] val);
    if (alu) begin
      bus.alu_cdb_rdy_in = 1'b1;
      bus.alu_cdb_dep_in = tag;
      bus.alu_cdb_val_in = val;
    end else begin
      bus.lsb_cdb_rdy_in = 1'b1;
      bus.lsb_cdb_dep_in = tag;
      bus.lsb_cdb_val_in = val;
    end
  endtask

  task automatic push(input logic [31:0] o1, input logic [31:0] o2, input logic [4:0] dep,
                      input logic [3:0] l1, input logic l2);
    exp_t e;
    e.o1 = o1; e.o2 = o2; e.dep = dep; e.l1 = l1; e.l2 = l2;
    sbq.push_back(e);
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) step();
    chk("scoreboard_empty", sbq.size(), 0);
  endtask

  // Every issue seen on the ALU port must match the next expected op.
  always @(negedge clk) begin
    if (rst_n && mon_en && bus.alu_valid_out) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got dep=%h opr1=%h opr2=%h expected no issue",
                 bus.alu_dep_out, bus.alu_opr1_out, bus.alu_opr2_out);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.alu_opr1_out !== mon_e.o1 || bus.alu_opr2_out !== mon_e.o2 ||
            bus.alu_dep_out !== mon_e.dep || bus.alu_op_L1_out !== mon_e.l1 ||
            bus.alu_op_L2_out !== mon_e.l2) begin
          n_err++;
          $display("FAIL issue: got %h/%h/%h/%h/%b expected %h/%h/%h/%h/%b",
                   bus.alu_opr1_out, bus.alu_opr2_out, bus.alu_dep_out, bus.alu_op_L1_out,
                   bus.alu_op_L2_out, mon_e.o1, mon_e.o2, mon_e.dep, mon_e.l1, mon_e.l2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.rdy_in = 1'b1;
    idle();
    disp_set(4'd0, 1'b0, 32'd0, NT, 32'd0, NT, 5'd0);
    bus.disp_valid_in = 1'b0;
    cdb(1'b1, NT, 32'd0);
    cdb(1'b0, NT, 32'd0);
    idle();
    step();
    chk("rst_valid", bus.alu_valid_out, 0);
    chk("rst_opr1", bus.alu_opr1_out, 0);
    chk("rst_opr2", bus.alu_opr2_out, 0);
    chk("rst_dep", bus.alu_dep_out, NT);
    chk("rst_l1", bus.alu_op_L1_out, 0);
    chk("rst_l2", bus.alu_op_L2_out, 0);
    chk("rst_full", bus.full_out, 0);
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // Table: ready ops and dispatch-cycle bypass from either CDB.
    vecs[0] = '{4'd0, 1'b0, 32'd5, NT, 32'd7, NT, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                32'd5, 32'd7};
    vecs[1] = '{4'd1, 1'b0, 32'hdeadbeef, NT, 32'h1234, NT, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0,
                5'd0, 32'd0, 32'hdeadbeef, 32'h1234};
    vecs[2] = '{4'd2, 1'b1, 32'd0, 5'd6, 32'd3, NT, 5'd2, 1'b1, 5'd6, 32'haaaa, 1'b0, 5'd0,
                32'd0, 32'haaaa, 32'd3};
    vecs[3] = '{4'd5, 1'b0, 32'd9, NT, 32'd0, 5'd7, 5'd13, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7,
                32'h77, 32'd9, 32'h77};
    vecs[4] = '{4'd6, 1'b1, 32'd0, 5'd8, 32'd0, 5'd8, 5'd14, 1'b1, 5'd8, 32'h1, 1'b1, 5'd8,
                32'h2, 32'h1, 32'h1};
    vecs[5] = '{4'd7, 1'b0, 32'd0, 5'd2, 32'd0, 5'd3, 5'd15, 1'b1, 5'd2, 32'h20, 1'b1, 5'd3,
                32'h30, 32'h20, 32'h30};
    vecs[6] = '{4'd15, 1'b1, 32'hffffffff, NT, 32'd0, NT, 5'd30, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                32'd0, 32'hffffffff, 32'd0};
    for (int i = 0; i < 7; i++) begin
      disp_set(vecs[i].op1, vecs[i].op2, vecs[i].vj, vecs[i].qj, vecs[i].vk, vecs[i].qk,
               vecs[i].rob);
      if (vecs[i].a_rdy) cdb(1'b1, vecs[i].a_tag, vecs[i].a_val);
      if (vecs[i].l_rdy) cdb(1'b0, vecs[i].l_tag, vecs[i].l_val);
      push(vecs[i].e1, vecs[i].e2, vecs[i].rob, vecs[i].op1, vecs[i].op2);
      step();
      idle();
    end
    drain(4);

    // Ready dispatch issues exactly one edge later, for one cycle.
    push(32'd5, 32'd7, 5'd3, 4'd0, 1'b0);
    dispatch(4'd0, 1'b0, 32'd5, NT, 32'd7, NT, 5'd3);
    chk("lat_n_valid", bus.alu_valid_out, 0);
    step();
    chk("lat_n1_valid", bus.alu_valid_out, 1);
    chk("lat_n1_dep", bus.alu_dep_out, 3);
    step();
    chk("lat_n2_valid", bus.alu_valid_out, 0);

    // Wakeup from LSB CDB two cycles after dispatch.
    dispatch(4'd0, 1'b1, 32'd0, 5'd2, 32'd1, NT, 5'd4);
    step();
    cdb(1'b0, 5'd2, 32'h10);
    push(32'h10, 32'd1, 5'd4, 4'd0, 1'b1);
    step();
    idle();
    chk("wake_same_cycle_valid", bus.alu_valid_out, 0);
    step();
    chk("wake_issue_valid", bus.alu_valid_out, 1);
    chk("wake_issue_opr1", bus.alu_opr1_out, 32'h10);
    drain(2);

    // Same op with the CDB in the dispatch cycle.
    disp_set(4'd0, 1'b1, 32'd0, 5'd2, 32'd1, NT, 5'd4);
    cdb(1'b0, 5'd2, 32'h10);
    push(32'h10, 32'd1, 5'd4, 4'd0, 1'b1);
    step();
    idle();
    chk("byp_n_valid", bus.alu_valid_out, 0);
    step();
    chk("byp_issue_valid", bus.alu_valid_out, 1);
    drain(2);

    // Wakeup with both CDBs on the same tag: ALU value wins.
    dispatch(4'd4, 1'b0, 32'd2, NT, 32'd0, 5'd11, 5'd5);
    cdb(1'b1, 5'd11, 32'ha1);
    cdb(1'b0, 5'd11, 32'hb2);
    push(32'd2, 32'ha1, 5'd5, 4'd4, 1'b0);
    step();
    idle();
    drain(3);

    // Fill all entries waiting on tag 9; extra dispatch while full is dropped.
    for (int i = 0; i < 8; i++) begin
      dispatch(4'd2, 1'b0, 32'd0, 5'd9, 32'(i), NT, 5'(i));
    end
    chk("fill_full", bus.full_out, 1);
    dispatch(4'd2, 1'b0, 32'h99, NT, 32'h99, NT, 5'd12);
    chk("full_after_drop", bus.full_out, 1);
    cdb(1'b1, 5'd9, 32'h900);
    for (int i = 0; i < 8; i++) push(32'h900, 32'(i), 5'(i), 4'd2, 1'b0);
    step();
    idle();
    chk("full_before_issue", bus.full_out, 1);
    step();
    chk("first_issue_valid", bus.alu_valid_out, 1);
    chk("full_drop", bus.full_out, 0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("consecutive_valid", bus.alu_valid_out, 1);
    end
    drain(4);

    // Flush with pending entries and a same-cycle dispatch.
    dispatch(4'd1, 1'b0, 32'd0, 5'd10, 32'd1, NT, 5'd20);
    dispatch(4'd1, 1'b0, 32'd0, 5'd10, 32'd2, NT, 5'd21);
    dispatch(4'd1, 1'b0, 32'd3, NT, 32'd3, NT, 5'd23);
    disp_set(4'd1, 1'b0, 32'd4, NT, 32'd4, NT, 5'd24);
    bus.need_flush_in = 1'b1;
    step();
    idle();
    chk("flush_valid", bus.alu_valid_out, 0);
    chk("flush_full", bus.full_out, 0);
    cdb(1'b1, 5'd10, 32'h5);
    step();
    idle();
    drain(5);

    // rdy_in low freezes everything, including a held alu_valid_out.
    mon_en = 1'b0;
    dispatch(4'd3, 1'b0, 32'h11, NT, 32'h22, NT, 5'd8);
    step();
    chk("hold_pre_valid", bus.alu_valid_out, 1);
    bus.rdy_in = 1'b0;
    disp_set(4'd3, 1'b0, 32'h33, NT, 32'h33, NT, 5'd9);
    step();
    step();
    chk("hold_valid", bus.alu_valid_out, 1);
    chk("hold_opr1", bus.alu_opr1_out, 32'h11);
    idle();
    bus.rdy_in = 1'b1;
    step();
    chk("hold_release_valid", bus.alu_valid_out, 0);
    step();
    mon_en = 1'b1;

    // Asynchronous reset mid-run while an op is issuing and another waits.
    mon_en = 1'b0;
    dispatch(4'd3, 1'b0, 32'd0, 5'd7, 32'h1, NT, 5'd6);
    dispatch(4'd3, 1'b0, 32'h55, NT, 32'h1, NT, 5'd7);
    step();
    chk("pre_rst_valid", bus.alu_valid_out, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.alu_valid_out, 0);
    chk("mid_rst_dep", bus.alu_dep_out, NT);
    chk("mid_rst_opr1", bus.alu_opr1_out, 0);
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();
    cdb(1'b1, 5'd7, 32'h7);
    step();
    idle();
    drain(4);

    // Older entry at higher index vs younger entry at index 0, woken together.
    push(32'h50, 32'ha, 5'd10, 4'd3, 1'b0);
    dispatch(4'd3, 1'b0, 32'd0, 5'd5, 32'ha, NT, 5'd10);
    dispatch(4'd3, 1'b0, 32'd0, 5'd6, 32'hb, NT, 5'd11);
    cdb(1'b1, 5'd5, 32'h50);
    step();
    idle();
    step();
    dispatch(4'd3, 1'b0, 32'd0, 5'd6, 32'hc, NT, 5'd12);
`ifdef ALU_RS_AGE_SELECT_EN
    push(32'h60, 32'hb, 5'd11, 4'd3, 1'b0);
    push(32'h60, 32'hc, 5'd12, 4'd3, 1'b0);
`else
    push(32'h60, 32'hc, 5'd12, 4'd3, 1'b0);
    push(32'h60, 32'hb, 5'd11, 4'd3, 1'b0);
`endif
    cdb(1'b1, 5'd6, 32'h60);
    step();
    idle();
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
